reg_write_arbiter: RTL and testbench

//  Shares the single register-file write port (WRITE/INADDRESS/IN) between two requesters:

---
 rtl/reg_write_arbiter.sv | 76 +++++++
 tb/tb_reg_write_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester arbiter for the register-file write port with a registered req/gnt handshake.
// Round-robin by default; define REG_WRITE_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 first).
module reg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] DATA0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA1,
  output logic              GNT1,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic              BUSY
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t state;
  logic   elig0;
  logic   elig1;
  logic   win1;

`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
  logic   last;
`endif

  // A requester granted this cycle is masked for one edge so its held REQ is not re-granted.
  always_comb begin
    elig0 = REQ0 & ~GNT0;
    elig1 = REQ1 & ~GNT1;
`ifdef REG_WRITE_ARBITER_FIXED_PRIO_EN
    win1  = elig1 & ~elig0;
`else
    win1  = elig1 & (~elig0 | ~last);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      WRITE     <= 1'b0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else if (elig0 | elig1) begin
      state     <= GRANT;
      WRITE     <= 1'b1;
      GNT0      <= ~win1;
      GNT1      <= win1;
      INADDRESS <= win1 ? ADDR1 : ADDR0;
      IN        <= win1 ? DATA1 : DATA0;
`ifndef REG_WRITE_ARBITER_FIXED_PRIO_EN
      last      <= win1;
`endif
    end else begin
      state     <= IDLE;
      WRITE     <= 1'b0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
    end
  end

  assign BUSY = (state == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios plus a randomized run against a bench model.
module tb_reg_write_arbiter;

  logic       CLK;
  logic       RESET;
  logic       REQ0, REQ1;
  logic [2:0] ADDR0, ADDR1;
  logic [7:0] DATA0, DATA1;
  logic       GNT0, GNT1, WRITE, BUSY;
  logic [2:0] INADDRESS;
  logic [7:0] IN;

  typedef struct packed {
    logic       wr;
    logic       g0;
    logic       g1;
    logic       busy;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       r0;
    logic [2:0] a0;
    logic [7:0] d0;
    logic       r1;
    logic [2:0] a1;
    logic [7:0] d1;
  } stim_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // bench model state for the randomized run
  logic       m_g0, m_g1, m_last;
  logic [2:0] m_addr;
  logic [7:0] m_data;

  reg_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .ADDR0(ADDR0), .DATA0(DATA0), .GNT0(GNT0),
    .REQ1(REQ1), .ADDR1(ADDR1), .DATA1(DATA1), .GNT1(GNT1),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic apply(input stim_t s);
    RESET = s.rst;
    REQ0  = s.r0;  ADDR0 = s.a0;  DATA0 = s.d0;
    REQ1  = s.r1;  ADDR1 = s.a1;  DATA1 = s.d1;
  endtask

  task automatic test_reset();
    stim_t st[2];
    exp_t  ex[2];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b1, 3'd7, 8'hFF, 1'b1, 3'd7, 8'hFF};
    st[1] = st[0];
    ex[0] = '0;
    ex[1] = '0;
    for (int i = 0; i < 2; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_single();
    stim_t st[3];
    exp_t  ex[3];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
    st[1] = '{1'b0, 1'b1, 3'd3, 8'h2A, 1'b0, 3'd0, 8'h00};
    st[2] = '{1'b0, 1'b0, 3'd3, 8'h2A, 1'b0, 3'd0, 8'h00};
    ex[0] = '0;
    ex[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h2A};
    ex[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h2A};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL single[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_contention();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b1, 3'd1, 8'h05, 1'b1, 3'd2, 8'h09};
    for (int i = 1; i < 5; i++) st[i] = '{1'b0, 1'b1, 3'd1, 8'h05, 1'b1, 3'd2, 8'h09};
    ex[0] = '0;
    ex[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h05};
    ex[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h09};
    ex[3] = ex[1];
    ex[4] = ex[2];
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL contention[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_held_request();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
    for (int i = 1; i < 5; i++) st[i] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'hC3};
    ex[0] = '0;
    ex[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'hC3};
    ex[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 8'hC3};
    ex[3] = ex[1];
    ex[4] = ex[2];
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL held_request[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_mid_write_reset();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
    st[1] = '{1'b0, 1'b1, 3'd4, 8'h77, 1'b0, 3'd0, 8'h00};
    st[2] = '{1'b1, 1'b1, 3'd4, 8'h77, 1'b1, 3'd1, 8'h33};
    st[3] = st[2];
    st[4] = '{1'b0, 1'b1, 3'd4, 8'h77, 1'b1, 3'd1, 8'h33};
    ex[0] = '0;
    ex[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'h77};
    ex[2] = '0;
    ex[3] = '0;
    ex[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'h77};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mid_write_reset[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  // Pointer test: requester 0 wins alone, an idle edge, then both request unmasked.
  task automatic test_rr_pointer();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
    st[1] = '{1'b0, 1'b1, 3'd2, 8'hA1, 1'b0, 3'd0, 8'h00};
    st[2] = '{1'b0, 1'b0, 3'd2, 8'hA1, 1'b0, 3'd0, 8'h00};
    st[3] = '{1'b0, 1'b1, 3'd2, 8'hA1, 1'b1, 3'd5, 8'hB2};
    st[4] = st[3];
    ex[0] = '0;
    ex[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'hA1};
    ex[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'hA1};
`ifdef REG_WRITE_ARBITER_FIXED_PRIO_EN
    ex[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'hA1};
    ex[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'hB2};
`else
    ex[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'hB2};
    ex[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 8'hA1};
`endif
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL rr_pointer[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  // Same destination on both requesters; REQ1 rises while GNT0 is high.
  task automatic test_back_to_back();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  got, want;
    st[0] = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00};
    st[1] = '{1'b0, 1'b1, 3'd5, 8'h11, 1'b0, 3'd0, 8'h00};
    st[2] = '{1'b0, 1'b1, 3'd5, 8'h11, 1'b1, 3'd5, 8'h22};
    st[3] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h22};
    ex[0] = '0;
    ex[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'h11};
    ex[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h22};
    ex[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h22};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    exp_t  e, got, want;
    logic  e0, e1, w1;
    for (int i = 0; i < 200; i++) begin
      s.rst = (i == 0) || ($urandom_range(0, 19) == 0);
      s.r0  = $urandom_range(0, 1);
      s.a0  = 3'($urandom_range(0, 7));
      s.d0  = 8'($urandom_range(0, 255));
      s.r1  = $urandom_range(0, 1);
      s.a1  = 3'($urandom_range(0, 7));
      s.d1  = 8'($urandom_range(0, 255));
      if (s.rst) begin
        m_g0 = 1'b0; m_g1 = 1'b0; m_last = 1'b1; m_addr = '0; m_data = '0;
        e = '0;
      end else begin
        e0 = s.r0 && !m_g0;
        e1 = s.r1 && !m_g1;
        if (!e0 && !e1) begin
          m_g0 = 1'b0; m_g1 = 1'b0;
          e = '{1'b0, 1'b0, 1'b0, 1'b0, m_addr, m_data};
        end else begin
`ifdef REG_WRITE_ARBITER_FIXED_PRIO_EN
          w1 = !e0;
`else
          w1 = (e0 && e1) ? !m_last : e1;
`endif
          m_g0   = !w1;
          m_g1   = w1;
          m_last = w1;
          m_addr = w1 ? s.a1 : s.a0;
          m_data = w1 ? s.d1 : s.d0;
          e = '{1'b1, m_g0, m_g1, 1'b1, m_addr, m_data};
        end
      end
      apply(s);
      exp_q.push_back(e);
      @(posedge CLK); #1;
      want = exp_q.pop_front();
      got  = {WRITE, GNT0, GNT1, BUSY, INADDRESS, IN};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    REQ0 = 1'b0; ADDR0 = '0; DATA0 = '0;
    REQ1 = 1'b0; ADDR1 = '0; DATA1 = '0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_contention();
    test_held_request();
    test_mid_write_reset();
    test_rr_pointer();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
